calc_alu: RTL and testbench

CALC_ALU -- requirements
Module: calc_alu

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_iter_core.sv | 54 +++++
 rtl/calc_alu.sv | 139 +++++++++++++
 tb/tb_calc_alu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calc_alu block: operator codes, FSM state
// encoding and the default operand width.
package calc_pkg;

  localparam int CALC_WIDTH = 9;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/calc_iter_core.sv
// Bit-serial datapath shared by multiply (shift-add) and divide (restoring).
// The divide step exists only when CALC_ALU_DIV_EN is defined.
module calc_iter_core
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               load,
  input  logic               step,
  input  logic               div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] nxt
);

  // acc = {hi, lo}: product high half / multiplier, or remainder / quotient.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH:0]     sum;

  assign hi  = acc[2*WIDTH-1:WIDTH];
  assign lo  = acc[WIDTH-1:0];
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});

`ifdef CALC_ALU_DIV_EN
  logic [WIDTH:0] part;
  logic [WIDTH:0] diff;

  // Remainder stays below b, so bit WIDTH of diff is a clean borrow flag.
  assign part = {hi, lo[WIDTH-1]};
  assign diff = part - {1'b0, b};

  always_comb begin
    if (div) begin
      if (diff[WIDTH]) nxt = {part[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
      else             nxt = {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
    end else begin
      nxt = {sum, lo[WIDTH-1:1]};
    end
  end
`else
  logic unused_div;
  assign unused_div = div;
  assign nxt        = {sum, lo[WIDTH-1:1]};
`endif

  always_ff @(posedge clk) begin
    if (load)      acc <= {{WIDTH{1'b0}}, a};
    else if (step) acc <= nxt;
  end

endmodule

// File: rtl/calc_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB, bit-serial MUL and DIV.
// Define CALC_ALU_DIV_EN to build the divider; otherwise DIV reports error.
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic [1:0]         operator,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               negative,
  output logic               error
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_nxt;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [CW-1:0]      cnt;
  logic               load;
  logic               step;
  logic               fin;
  logic               iter;
  logic               res_neg;
  logic               res_err;
  logic [2*WIDTH-1:0] res_val;
  logic [2*WIDTH-1:0] core_nxt;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;

  assign ext_a = {{WIDTH{1'b0}}, a_q};
  assign ext_b = {{WIDTH{1'b0}}, b_q};

  calc_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk  (clk),
    .load (load),
    .step (step),
    .div  (op_q == OP_DIV),
    .a    (operand_a),
    .b    (b_q),
    .nxt  (core_nxt)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    iter      = 1'b0;
    res_val   = '0;
    res_neg   = 1'b0;
    res_err   = 1'b0;

    case (op_q)
      OP_ADD: res_val = ext_a + ext_b;
      OP_SUB: begin
        res_val = ext_a - ext_b;
        res_neg = (a_q < b_q);
      end
      OP_MUL: begin
        iter    = 1'b1;
        res_val = core_nxt;
      end
      OP_DIV: begin
`ifdef CALC_ALU_DIV_EN
        // Divide by zero bypasses iteration and finishes after one cycle.
        if (b_q == '0) begin
          res_err = 1'b1;
        end else begin
          iter    = 1'b1;
          res_val = core_nxt;
        end
`else
        res_err = 1'b1;
`endif
      end
      default: res_err = 1'b1;
    endcase

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_EXEC;
          load      = 1'b1;
        end
      end
      ST_EXEC: begin
        step = iter;
        if (!iter || cnt == CW'(WIDTH - 1)) begin
          state_nxt = ST_DONE;
          fin       = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load) begin
      a_q  <= operand_a;
      b_q  <= operand_b;
      op_q <= op_t'(operator);
    end
  end

  // Outputs are registered on the EXEC->DONE edge and held until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      result   <= '0;
      negative <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + CW'(1);
      if (fin) begin
        result   <= res_val;
        negative <= res_neg;
        error    <= res_err;
      end
    end
  end

  assign busy = (state == ST_EXEC);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_calc_alu.sv
// Scoreboard bench for calc_alu: stimulus pushes model results, a monitor
// pops and compares on every done pulse.
module tb_calc_alu;

  localparam int W  = 9;
  localparam int RW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [1:0]    operator;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          negative;
  logic          error;

  typedef struct {
    logic [RW-1:0] res;
    logic          neg;
    logic          err;
    int            lat;
    int            start_cyc;
  } exp_t;

  exp_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   cyc       = 0;
  int   done_seen = 0;
  int   issued    = 0;

  calc_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .operator  (operator),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .negative  (negative),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nm, act, act, req, req, cyc);
    end
  endtask

  function automatic exp_t model(int op, int a, int b, int sc);
    exp_t e;
    e.res = '0;
    e.neg = 1'b0;
    e.err = 1'b0;
    e.lat = 2;
    e.start_cyc = sc;
    case (op)
      0: e.res = RW'(a + b);
      1: begin
        e.res = RW'((a - b + (1 << RW)) % (1 << RW));
        e.neg = (a < b);
      end
      2: begin
        e.res = RW'(a * b);
        e.lat = W + 1;
      end
      default: begin
`ifdef CALC_ALU_DIV_EN
        if (b == 0) begin
          e.err = 1'b1;
        end else begin
          e.res = RW'((a % b) * (1 << W) + a / b);
          e.lat = W + 1;
        end
`else
        e.err = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",   result,   e.res);
        check("negative", negative, e.neg);
        check("error",    error,    e.err);
        check("latency",  cyc - e.start_cyc, e.lat);
      end
    end
  end

  // Caller must be positioned at a falling edge.
  task automatic issue(int op, int a, int b);
    int g = 0;
    while ((busy || done) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) check("idle_timeout", g, 0);
    operand_a = W'(a);
    operand_b = W'(b);
    operator  = 2'(op);
    start     = 1'b1;
    sb.push_back(model(op, a, b, cyc));
    issued++;
    @(negedge clk);
    start     = 1'b0;
    operand_a = W'($urandom);
    operand_b = W'($urandom);
    operator  = 2'($urandom);
    check("busy_in_exec", busy, 1);
  endtask

  task automatic wait_done();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!done && g < 40);
    if (!done) check("done_timeout", g, 0);
  endtask

  task automatic check_cleared(string tag);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_done"},     done,     0);
    check({tag, "_result"},   result,   0);
    check({tag, "_negative"}, negative, 0);
    check({tag, "_error"},    error,    0);
  endtask

  initial begin
    int op, a, b, sel;
    rst_n     = 1'b0;
    start     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    operator  = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;

    issue(0, 200, 311); wait_done();
    issue(1, 5, 9);     wait_done();
    issue(2, 511, 511); wait_done();
    issue(3, 100, 7);   wait_done();
    issue(3, 37, 0);    wait_done();
    issue(1, 9, 5);     wait_done();
    issue(0, 511, 511); wait_done();

    // start pulsed while a multiply is in flight must be dropped
    issue(2, 511, 511);
    repeat (3) @(negedge clk);
    operand_a = W'(3);
    operand_b = W'(4);
    operator  = 2'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);

    // reset in the middle of a multiply aborts it
    issue(0, 200, 311); wait_done();
    issue(2, 300, 400);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_cleared("abort");
    sb.delete();
    issued--;
    repeat (2) @(negedge clk);
    check_cleared("held");
    rst_n = 1'b1;
    issue(0, 1, 1); wait_done();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      op  = int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 7));
      a   = (sel == 0) ? 0 : (sel == 1) ? 511 : int'($urandom_range(0, 511));
      b   = (sel == 2) ? 0 : (sel == 3) ? 511 : int'($urandom_range(0, 511));
      issue(op, a, b);
      wait_done();
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("done_count", done_seen, issued);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
